pipe_control_unit: RTL

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

---
 rtl/pipe_control_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pipe_control_unit.sv
// ID-stage control: opcode decode, ID/EX control register, hazard tracker and illegal-opcode counter.
// Build option FWD_HAZARD_EN: forwarding exists downstream, so only load-use hazards stall.
module pipe_control_unit #(
    parameter int OPCODE_W  = 6,
    parameter int REG_W     = 5,
    parameter int HAZ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] op_code,
    input  logic [REG_W-1:0]    src1,
    input  logic [REG_W-1:0]    src2,
    input  logic [REG_W-1:0]    dest,
    input  logic                freeze,
    input  logic                flush,
    output logic                hazard_stall,
    output logic                out_valid,
    output logic                is_immediate,
    output logic                ST_or_BNE,
    output logic                is_branch_or_jump,
    output logic                MEM_R_en,
    output logic                MEM_W_en,
    output logic                WB_en,
    output logic [1:0]          branch_type,
    output logic [3:0]          EXE_cmd,
    output logic [REG_W-1:0]    dest_out,
    output logic                illegal_op,
    output logic [7:0]          illegal_cnt
);

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    typedef struct packed {
        logic             valid;
        logic             wb;
        logic             memr;
        logic [REG_W-1:0] dest;
    } trk_t;

    trk_t trk [HAZ_DEPTH];

    logic [5:0]          op_lo;
    logic [OPCODE_W-1:0] op_hi;
    logic                hi_zero;
    logic                d_legal, d_imm, d_stb, d_br, d_memr, d_memw, d_wb;
    logic [1:0]          d_bt;
    logic [3:0]          d_exe;
    logic                is_nop, use_src1, use_src2;
    logic                hit, take;

    assign op_lo   = op_code[5:0];
    assign op_hi   = op_code >> 6;
    assign hi_zero = (op_hi == '0);

    // Decode; anything outside the table (or with upper opcode bits set) becomes an illegal NOP
    always_comb begin
        d_legal = 1'b1;
        d_imm   = 1'b0;
        d_stb   = 1'b0;
        d_br    = 1'b0;
        d_memr  = 1'b0;
        d_memw  = 1'b0;
        d_wb    = 1'b0;
        d_bt    = 2'd0;
        d_exe   = 4'd0;
        if (!hi_zero) begin
            d_legal = 1'b0;
        end else begin
            case (op_lo)
                OP_NOP:  ;
                OP_ADD:  begin d_exe = 4'd0;  d_wb = 1'b1; end
                OP_SUB:  begin d_exe = 4'd2;  d_wb = 1'b1; end
                OP_AND:  begin d_exe = 4'd4;  d_wb = 1'b1; end
                OP_OR:   begin d_exe = 4'd5;  d_wb = 1'b1; end
                OP_NOR:  begin d_exe = 4'd6;  d_wb = 1'b1; end
                OP_XOR:  begin d_exe = 4'd7;  d_wb = 1'b1; end
                OP_SLA,
                OP_SLL:  begin d_exe = 4'd8;  d_wb = 1'b1; end
                OP_SRA:  begin d_exe = 4'd9;  d_wb = 1'b1; end
                OP_SRL:  begin d_exe = 4'd10; d_wb = 1'b1; end
                OP_ADDI: begin d_exe = 4'd0;  d_imm = 1'b1; d_wb = 1'b1; end
                OP_SUBI: begin d_exe = 4'd2;  d_imm = 1'b1; d_wb = 1'b1; end
                OP_LD:   begin d_exe = 4'd0;  d_imm = 1'b1; d_memr = 1'b1; d_wb = 1'b1; end
                OP_ST:   begin d_exe = 4'd0;  d_imm = 1'b1; d_stb = 1'b1; d_memw = 1'b1; end
                OP_BEZ:  begin d_imm = 1'b1;  d_br = 1'b1;  d_bt = 2'd0; end
                OP_BNE:  begin d_imm = 1'b1;  d_stb = 1'b1; d_br = 1'b1; d_bt = 2'd1; end
                OP_JMP:  begin d_imm = 1'b1;  d_br = 1'b1;  d_bt = 2'd2; end
                default: d_legal = 1'b0;
            endcase
        end
    end

    assign is_nop   = (op_lo == OP_NOP) | ~d_legal;
    assign use_src1 = in_valid & ~is_nop & (op_lo != OP_JMP);
    assign use_src2 = in_valid & ~is_nop & (~d_imm | d_stb);

    always_comb begin
        hit = 1'b0;
`ifdef FWD_HAZARD_EN
        if (trk[0].valid && trk[0].memr && (trk[0].dest != '0) &&
            ((use_src1 && (src1 == trk[0].dest)) || (use_src2 && (src2 == trk[0].dest))))
            hit = 1'b1;
`else
        // A load always writes back, so either flag marks an entry as a producer
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (trk[i].valid && (trk[i].wb || trk[i].memr) && (trk[i].dest != '0) &&
                ((use_src1 && (src1 == trk[i].dest)) || (use_src2 && (src2 == trk[i].dest))))
                hit = 1'b1;
        end
`endif
    end

    assign hazard_stall = in_valid & ~flush & hit;
    assign take         = in_valid & ~flush & ~hazard_stall;

    // ID/EX register and tracker advance together; a bubble is an all-zero bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid         <= 1'b0;
            is_immediate      <= 1'b0;
            ST_or_BNE         <= 1'b0;
            is_branch_or_jump <= 1'b0;
            MEM_R_en          <= 1'b0;
            MEM_W_en          <= 1'b0;
            WB_en             <= 1'b0;
            branch_type       <= 2'd0;
            EXE_cmd           <= 4'd0;
            dest_out          <= '0;
            illegal_op        <= 1'b0;
            for (int i = 0; i < HAZ_DEPTH; i++) trk[i] <= '0;
        end else if (!freeze) begin
            out_valid         <= take;
            is_immediate      <= take & d_imm;
            ST_or_BNE         <= take & d_stb;
            is_branch_or_jump <= take & d_br;
            MEM_R_en          <= take & d_memr;
            MEM_W_en          <= take & d_memw;
            WB_en             <= take & d_wb;
            branch_type       <= take ? d_bt : 2'd0;
            EXE_cmd           <= take ? d_exe : 4'd0;
            dest_out          <= take ? dest : '0;
            illegal_op        <= take & ~d_legal;
            trk[0].valid      <= take;
            trk[0].wb         <= take & d_wb;
            trk[0].memr       <= take & d_memr;
            trk[0].dest       <= take ? dest : '0;
            for (int i = HAZ_DEPTH - 1; i > 0; i--) trk[i] <= trk[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= 8'd0;
        end else if (!freeze && take && !d_legal && (illegal_cnt != 8'hFF)) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

endmodule
